// File: rtl/disp_seq_ctrl.sv
// disp_seq_ctrl: brings the sync generator out of reset, applies resolution
// changes and shutdown only at a vertical-sync boundary, counts frames.
// Optional feature: define DISP_TIMEOUT_EN to compile in the stall watchdog
// (TMO_ERR and automatic restart when vsync stops); otherwise TMO_ERR is 0.
module disp_seq_ctrl #(
  parameter int unsigned RSTLEN  = 16,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1500000
) (
  input  logic        DCLK,
  input  logic        DRST,
  input  logic        DSP_EN,
  input  logic [1:0]  RESOL_IN,
  input  logic        DSP_VSYNC_X,
  output logic        SG_RST,
  output logic [1:0]  SG_RESOL,
  output logic        SG_VRSTART,
  output logic        RUNNING,
  output logic [15:0] FRAME_CNT,
  output logic        TMO_ERR
);

  localparam int unsigned PH_MAX = (RSTLEN > SETTLE) ? RSTLEN : SETTLE;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned FC_W   = 16;

  typedef enum logic [2:0] {
    S_OFF, S_HOLD, S_SETTLE, S_START, S_RUN, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [1:0]        resol_q, resol_d;
  logic [FC_W-1:0]   fc_d;
  logic              tmo_d;
  logic              vs_q;
  logic              vf;
  logic              stall;
  logic              resol_diff;

  assign vf         = vs_q & ~DSP_VSYNC_X;
  assign resol_diff = (RESOL_IN != resol_q);

`ifdef DISP_TIMEOUT_EN
  localparam int unsigned WD_W = 21;
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: counts while frames are expected, cleared by every vsync fall
  always_comb begin
    wd_d  = '0;
    stall = 1'b0;
    if (state_q == S_RUN || state_q == S_DRAIN) begin
      if (vf) begin
        wd_d = '0;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        stall = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge DCLK) begin
    if (DRST) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  assign stall = 1'b0;
`endif

  // Next-state, phase counter, latched resolution, frame count and error flag
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    resol_d = resol_q;
    fc_d    = FRAME_CNT;
    tmo_d   = TMO_ERR;
    case (state_q)
      S_OFF: begin
        if (DSP_EN) begin
          state_d = S_HOLD;
          ph_d    = '0;
          resol_d = RESOL_IN;
        end
      end
      S_HOLD: begin
        if (ph_q == PH_W'(RSTLEN - 1)) begin
          state_d = S_SETTLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (ph_q == PH_W'(SETTLE - 1)) begin
          state_d = S_START;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_RUN;
        fc_d    = '0;
      end
      S_RUN: begin
        if (vf) fc_d = FRAME_CNT + 1'b1;
        if (!DSP_EN || resol_diff) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vf) begin
          fc_d = FRAME_CNT + 1'b1;
          if (!DSP_EN) begin
            state_d = S_OFF;
          end else if (resol_diff) begin
            state_d = S_HOLD;
            ph_d    = '0;
            resol_d = RESOL_IN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
    // A stalled timing chain overrides any pending run/drain decision
    if (stall) begin
      tmo_d = 1'b1;
      if (DSP_EN) begin
        state_d = S_HOLD;
        ph_d    = '0;
        resol_d = RESOL_IN;
      end else begin
        state_d = S_OFF;
      end
    end
  end

  // State, history and registered outputs (outputs follow the current state)
  always_ff @(posedge DCLK) begin
    if (DRST) begin
      state_q    <= S_OFF;
      ph_q       <= '0;
      resol_q    <= '0;
      vs_q       <= 1'b1;
      SG_RST     <= 1'b1;
      SG_RESOL   <= '0;
      SG_VRSTART <= 1'b0;
      RUNNING    <= 1'b0;
      FRAME_CNT  <= '0;
      TMO_ERR    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      resol_q    <= resol_d;
      vs_q       <= DSP_VSYNC_X;
      SG_RST     <= (state_q == S_OFF) || (state_q == S_HOLD);
      SG_RESOL   <= resol_q;
      SG_VRSTART <= (state_q == S_START);
      RUNNING    <= (state_q == S_RUN) || (state_q == S_DRAIN);
      FRAME_CNT  <= fc_d;
      TMO_ERR    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Testbench for disp_seq_ctrl: randomized stimulus, per-cycle expected
// outputs from a timing-arithmetic reference model, checked by a monitor.
module tb_disp_seq_ctrl;

  localparam int unsigned RSTLEN  = 16;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned START_T = RSTLEN + SETTLE + 1;

  logic        DCLK = 1'b0;
  logic        DRST = 1'b1;
  logic        DSP_EN = 1'b0;
  logic [1:0]  RESOL_IN = 2'd0;
  logic        DSP_VSYNC_X = 1'b1;
  logic        SG_RST;
  logic [1:0]  SG_RESOL;
  logic        SG_VRSTART;
  logic        RUNNING;
  logic [15:0] FRAME_CNT;
  logic        TMO_ERR;

  disp_seq_ctrl #(.RSTLEN(RSTLEN), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .DCLK(DCLK), .DRST(DRST), .DSP_EN(DSP_EN), .RESOL_IN(RESOL_IN),
    .DSP_VSYNC_X(DSP_VSYNC_X), .SG_RST(SG_RST), .SG_RESOL(SG_RESOL),
    .SG_VRSTART(SG_VRSTART), .RUNNING(RUNNING), .FRAME_CNT(FRAME_CNT),
    .TMO_ERR(TMO_ERR)
  );

  always #5 DCLK = ~DCLK;

  typedef struct packed {
    logic        rst;
    logic [1:0]  resol;
    logic        vr;
    logic        run;
    logic [15:0] fc;
    logic        tmo;
  } obs_t;

  obs_t exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: mode 0 = off, 1 = restart sequence (t edges since the
  // enabling edge), 2 = live (frames flowing, m_drain = change pending)
  int          m_mode = 0;
  int unsigned m_t = 0;
  bit          m_drain = 0;
  logic [1:0]  m_resol = 2'd0;
  logic [15:0] m_fc = 16'd0;
  bit          m_tmo = 0;
  bit          m_vs = 1;
  int unsigned m_wd = 0;

  task automatic begin_restart(input logic [1:0] res);
    m_resol = res;
    m_mode  = 1;
    m_t     = 1;
  endtask

  // Predict the outputs seen after the next clock edge for these inputs
  task automatic model_edge(input bit rst, input bit en, input logic [1:0] res, input bit vs);
    obs_t e;
    bit   vf;
    bit   stalled;
    e = '0;
    if (rst) begin
      m_mode = 0; m_t = 0; m_drain = 0; m_resol = 2'd0;
      m_fc = 16'd0; m_tmo = 0; m_vs = 1; m_wd = 0;
      e.rst = 1'b1;
      exp_q.push_back(e);
      return;
    end
    vf      = m_vs && !vs;
    m_vs    = vs;
    stalled = 0;
    e.resol = m_resol;
    case (m_mode)
      0: begin
        e.rst = 1'b1;
        if (en) begin_restart(res);
      end
      1: begin
        e.rst = (m_t <= RSTLEN);
        if (m_t == START_T) begin
          e.vr = 1'b1;
          m_fc = 16'd0;
          m_mode = 2; m_drain = 0; m_wd = 0;
        end else begin
          m_t++;
        end
      end
      default: begin
        e.run = 1'b1;
        if (vf) begin
          m_fc = m_fc + 16'd1;
          m_wd = 0;
        end
`ifdef DISP_TIMEOUT_EN
        else if (m_wd == TIMEOUT - 1) stalled = 1;
        else m_wd++;
`endif
        if (stalled) begin
          m_tmo = 1;
          if (en) begin_restart(res);
          else m_mode = 0;
        end else if (!m_drain) begin
          if (!en || res != m_resol) m_drain = 1;
        end else if (vf) begin
          if (!en) m_mode = 0;
          else if (res != m_resol) begin_restart(res);
          else m_drain = 0;
        end
      end
    endcase
    e.fc  = m_fc;
    e.tmo = m_tmo;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented output vector with the oldest expectation
  initial begin
    obs_t act;
    obs_t e;
    int unsigned cyc = 0;
    forever begin
      @(posedge DCLK);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {SG_RST, SG_RESOL, SG_VRSTART, RUNNING, FRAME_CNT, TMO_ERR};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL outputs@cycle%0d got rst=%b resol=%0d vrstart=%b running=%b fcnt=%0d tmo=%b, expected rst=%b resol=%0d vrstart=%b running=%b fcnt=%0d tmo=%b",
                   cyc, act.rst, act.resol, act.vr, act.run, act.fc, act.tmo,
                   e.rst, e.resol, e.vr, e.run, e.fc, e.tmo);
        end
      end
    end
  end

  // Expired-wait guard: the whole sequence must finish in bounded time
  initial begin
    #(64'd5_000_000);
    miscompares++;
    $display("FAIL timeout: test did not complete within the wait limit");
    $finish;
  end

  // Reset-state check: outputs after the edge that sampled DRST=1
  task automatic check_reset_state(input string tag);
    @(posedge DCLK);
    #1;
    if (SG_RST !== 1'b1 || SG_RESOL !== 2'd0 || SG_VRSTART !== 1'b0 ||
        RUNNING !== 1'b0 || FRAME_CNT !== 16'd0 || TMO_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state (%s): rst=%b resol=%0d vrstart=%b running=%b fcnt=%0d tmo=%b",
               tag, SG_RST, SG_RESOL, SG_VRSTART, RUNNING, FRAME_CNT, TMO_ERR);
    end
  endtask

  // Stimulus state: requested enable/resolution and a vsync pattern generator
  bit          d_en = 0;
  logic [1:0]  d_res = 2'd0;
  int unsigned g_period = 40;
  int unsigned g_low = 4;
  int unsigned g_ph = 10;
  bit          g_hold = 0;
  bit          g_rand = 0;

  task automatic tick(input bit rst);
    bit vs;
    vs = g_hold ? 1'b1 : (g_ph >= g_low);
    if (!g_hold) begin
      g_ph++;
      if (g_ph >= g_period) begin
        g_ph = 0;
        if (g_rand) begin
          g_period = $urandom_range(50, 6);
          g_low    = $urandom_range(3, 1);
        end
      end
    end
    @(negedge DCLK);
    DRST = rst; DSP_EN = d_en; RESOL_IN = d_res; DSP_VSYNC_X = vs;
    model_edge(rst, d_en, d_res, vs);
  endtask

  task automatic run(input int unsigned n);
    bit r;
    for (int unsigned i = 0; i < n; i++) begin
      r = 0;
      if (g_rand) begin
        if ($urandom_range(59, 0) == 0) d_en = !d_en;
        if ($urandom_range(49, 0) == 0) d_res = 2'($urandom_range(3, 0));
        if ($urandom_range(1499, 0) == 0) r = 1;
      end
      tick(r);
    end
  endtask

  task automatic run_to_ph(input int unsigned p);
    for (int i = 0; i < 200 && g_ph != p; i++) run(1);
  endtask

  initial begin
    // Reset and idle
    repeat (3) tick(1);
    check_reset_state("initial");
    run(5);
    // Bring-up at resolution 2, then a few frames
    d_res = 2'd2; d_en = 1;
    run(160);
    // Resolution change 2 -> 1 mid-frame
    run_to_ph(20); d_res = 2'd1;
    run(200);
    // Withdrawn request 1 -> 2 -> 1 before the next vsync fall
    run_to_ph(10); d_res = 2'd2;
    run(5);        d_res = 2'd1;
    run(100);
    // Shutdown mid-frame
    run_to_ph(20); d_en = 0;
    run(100);
    // Restart, then reset pulsed while settling
    d_res = 2'd3; d_en = 1;
    run(18);
    tick(1);
    check_reset_state("settle");
    run(120);
    // Randomized traffic
    g_rand = 1;
    run(4000);
    g_rand = 0;
    g_period = 30; g_low = 2; g_ph = 5;
    d_en = 1; d_res = 2'd1;
    run(150);
    // Stall with display requested: restart follows, error flag is sticky
    g_hold = 1;
    run(1100);
    g_hold = 0;
    run(150);
    // Stall with display withdrawn
    g_hold = 1; d_en = 0;
    run(1100);
    g_hold = 0;
    run(20);
    // Frame counter wrap with the fastest possible frames
    d_en = 1; d_res = 2'd0;
    g_period = 2; g_low = 1; g_ph = 0;
    run(2 * 65536 + 60);
    repeat (3) @(posedge DCLK);
    #2;
    if (vectors == 0 || miscompares != 0)
      $display("FAIL summary: %0d vectors applied, %0d miscompares", vectors, miscompares);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
